tc_timer: RTL and testbench
===========================

# tc_timer

Programmable countdown timer that acts as a responder on the CPU data bus (word address, byte enables, write data, read data) and drives one hardware interrupt line into the CPU's `hwInt` input. It sits behind the system bridge: the bridge decodes the base address and asserts `sel`, and this block owns the low address bits. It provides three word registers (CTRL, PRESET, COUNT), a four-state countdown FSM, one-shot and auto-reload modes, and a maskable interrupt.

## Interface
Parameters:
- none; register map and field positions are fixed constants.

Ports:
- `clk`  in  1  single clock; every state element updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sel`  in  1  bridge select for this device.
- `addr`  in  2  word offset, i.e. bus address bits [3:2]. 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- `byteen`  in  4  byte-lane write enables; bit i covers `wdata[8i+7:8i]`.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, combinational from `addr`.
- `irq`  out  1  interrupt request to the CPU.

## Operation
Register write:
- A write occurs when `sel` is high and `byteen` is non-zero.
- Only the enabled byte lanes are merged into the addressed register.
- COUNT writes and reserved-offset writes are ignored.

CTRL register:
- bit 0 `en`.
- bits [2:1] `mode`: 0 = one-shot, 1 = auto-reload; 2 and 3 behave as 0.
- bit 3 `im`, the interrupt mask.
- bits [31:4] are not stored and read 0.

Read data:
- `rdata` returns CTRL (zero-extended), PRESET or COUNT according to `addr`; the reserved offset reads 0.
- `rdata` does not depend on `sel`.

Interrupt output:
- `irq` = `irq_flag` & `im`.

FSM states:
- IDLE: clears `irq_flag` only when a CTRL write happens. If `en` = 1, go to LOAD.
- LOAD: COUNT ← PRESET, go to CNT.
- CNT:
  - `en` = 0: go to IDLE; COUNT holds.
  - else COUNT = 0: set `irq_flag`, go to INT.
  - else COUNT ← COUNT − 1.
- INT, mode 0: clear `en`, go to IDLE; `irq_flag` stays set (sticky).
- INT, mode 1: clear `irq_flag`, go to LOAD.

Priority and boundary rules:
- A CTRL write at an edge forces state to IDLE and clears `irq_flag` at that edge. This overrides every FSM action, including the INT-state clear of `en`.
- A PRESET write updates PRESET only. A running count is unaffected until the next LOAD.
- PRESET = 0: LOAD → CNT → INT with no decrement.
- COUNT never wraps; it stops at 0.
- Reset mid-count returns every register and the FSM to reset values immediately, with no pending interrupt.

## Timing
Reset values:
- CTRL = 0, PRESET = 0, COUNT = 0.
- State = IDLE, `irq_flag` = 0.
- `irq` = 0, and `rdata` = 0 for every `addr`.

Write and read timing:
- A write is visible on `rdata` in the cycle after its edge.
- Reads have zero latency.

Countdown timing, for PRESET = N with CTRL written `en` = 1 at edge 0:
- edge 1: state becomes LOAD.
- edge 2: COUNT = N, state becomes CNT.
- edge N+2: COUNT = 0.
- edge N+3: state becomes INT and `irq` rises (if `im` = 1).

After the interrupt:
- Mode 1: `irq` is high for exactly one cycle and falls at edge N+4. COUNT = N again at edge N+5, so INT-to-INT spacing is N+3 cycles.
- Mode 0: at edge N+4 `en` = 0 and state = IDLE. `irq` stays high until the next CTRL write.

Mask behaviour:
- Toggling `im` via a CTRL write clears `irq_flag`. A masked interrupt therefore never appears later.

## Structure
- Shared constant header `tc_def.v`, included like the CPU's `def.v`, holds:
  - state encodings TC_IDLE/TC_LOAD/TC_CNT/TC_INT (2 bits);
  - register offsets;
  - CTRL bit positions;
  - mode codes.
- Single module, no sub-module. The byte-lane merge is a local function.

## Test plan
- Reset test: assert `reset` mid-count (COUNT = 5, state CNT) → same cycle: `irq` = 0, and reads of all offsets return 0.
- One-shot test: PRESET = 3, then CTRL = 0x9 → `irq` rises at edge 6 and stays high. CTRL then reads 0x8. A write of CTRL = 0x8 drops `irq` after that edge.
- Auto-reload test: PRESET = 2, CTRL = 0xB → `irq` pulses for one cycle at edges 5, 10 and 15. COUNT reads 2, 1, 0 in a repeating pattern.
- Masked test: PRESET = 0, CTRL = 0x1 → `irq` never rises and state returns to IDLE. Writing `im` afterwards does not raise `irq`.
- Byte-lane test: PRESET = 0x11223344, then a write of 0xAABBCCDD with `byteen` = 0b0101 → PRESET reads 0x11BB33DD. A COUNT write with `byteen` = 0xF leaves COUNT unchanged.
- Simultaneous-event test: a CTRL write of `en` = 1 lands on the INT edge in mode 0 → `en` stays 1, `irq_flag` clears, and the FSM restarts with LOAD on the next edge.

Source files
------------

// File: rtl/tc_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tc_timer_pkg
// Description : Shared constants for the tc_timer countdown timer.
//               Provides the FSM state encoding, register offsets, CTRL
//               field positions, mode codes and the byte-lane merge helper.
// Revision    : 1.0  initial release
// ============================================================================
package tc_timer_pkg;

  // Countdown FSM states (2-bit encoding)
  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_e;

  // Word offsets (bus address bits [3:2])
  localparam logic [1:0] TC_ADDR_CTRL   = 2'd0;
  localparam logic [1:0] TC_ADDR_PRESET = 2'd1;
  localparam logic [1:0] TC_ADDR_COUNT  = 2'd2;
  localparam logic [1:0] TC_ADDR_RSVD   = 2'd3;

  // CTRL field positions; only the low TC_CTRL_W bits are stored
  localparam int TC_CTRL_W        = 4;
  localparam int TC_CTRL_EN_BIT   = 0;
  localparam int TC_CTRL_MODE_LSB = 1;
  localparam int TC_CTRL_MODE_MSB = 2;
  localparam int TC_CTRL_IM_BIT   = 3;

  // Mode codes; codes 2 and 3 fall back to one-shot behaviour
  localparam logic [1:0] TC_MODE_ONESHOT = 2'd0;
  localparam logic [1:0] TC_MODE_RELOAD  = 2'd1;

  // Merge the enabled byte lanes of new_val into old_val
  function automatic logic [31:0] tc_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tc_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : tc_timer_if
// Description : CPU data-bus responder interface of the tc_timer.
//               master : bridge/CPU side (drives sel/addr/byteen/wdata)
//               slave  : timer side (drives rdata and irq)
// Ports       : sel    - bridge select for this device
//               addr   - word offset (bus address bits [3:2])
//               byteen - byte-lane write enables
//               wdata  - write data
//               rdata  - read data, combinational from addr
//               irq    - interrupt request to the CPU hwInt input
// Revision    : 1.0  initial release
// ============================================================================
interface tc_timer_if;
  logic        sel;
  logic [1:0]  addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output sel, output addr, output byteen, output wdata,
                  input  rdata, input irq);
  modport slave  (input  sel, input  addr, input  byteen, input  wdata,
                  output rdata, output irq);
endinterface
`default_nettype wire

// File: rtl/tc_timer.sv
`default_nettype none
// ============================================================================
// Module      : tc_timer
// Description : Programmable countdown timer on the CPU data bus.
//               Registers CTRL (en/mode/im), PRESET and read-only COUNT,
//               four-state countdown FSM with one-shot and auto-reload
//               modes and a maskable, sticky (one-shot) interrupt.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-high reset
//               bus   - tc_timer_if.slave (sel/addr/byteen/wdata in,
//                       rdata/irq out)
// Revision    : 1.0  initial release
// ============================================================================
module tc_timer
  import tc_timer_pkg::*;
(
  input  wire logic  clk,
  input  wire logic  reset,
  tc_timer_if.slave  bus
);

  logic [TC_CTRL_W-1:0] ctrl_q,     ctrl_d;
  logic [31:0]          preset_q,   preset_d;
  logic [31:0]          count_q,    count_d;
  tc_state_e            state_q,    state_d;
  logic                 irq_flag_q, irq_flag_d;
  logic                 irq_q,      irq_d;

  logic wr_en;
  logic ctrl_wr;
  logic preset_wr;
  logic mode_reload;

  assign wr_en       = bus.sel && (bus.byteen != 4'd0);
  assign ctrl_wr     = wr_en && (bus.addr == TC_ADDR_CTRL);
  assign preset_wr   = wr_en && (bus.addr == TC_ADDR_PRESET);
  assign mode_reload = (ctrl_q[TC_CTRL_MODE_MSB:TC_CTRL_MODE_LSB] == TC_MODE_RELOAD);

  // Next-state / next-register computation
  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    state_d    = state_q;
    irq_flag_d = irq_flag_q;

    // PRESET only feeds the next LOAD; a running count is not touched
    if (preset_wr) preset_d = tc_merge(preset_q, bus.wdata, bus.byteen);

    case (state_q)
      TC_IDLE: begin
        if (ctrl_q[TC_CTRL_EN_BIT]) state_d = TC_LOAD;
      end
      TC_LOAD: begin
        count_d = preset_q;
        state_d = TC_CNT;
      end
      TC_CNT: begin
        if (!ctrl_q[TC_CTRL_EN_BIT]) begin
          state_d = TC_IDLE;
        end else if (count_q == 32'd0) begin
          irq_flag_d = 1'b1;
          state_d    = TC_INT;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      TC_INT: begin
        if (mode_reload) begin
          irq_flag_d = 1'b0;
          state_d    = TC_LOAD;
        end else begin
          // One-shot: flag stays set until software rewrites CTRL
          ctrl_d[TC_CTRL_EN_BIT] = 1'b0;
          state_d                = TC_IDLE;
        end
      end
      default: state_d = TC_IDLE;
    endcase

    // A CTRL write wins over every FSM action at the same edge,
    // including the one-shot clear of en and any COUNT update.
    // Only byte lane 0 carries stored CTRL bits.
    if (ctrl_wr) begin
      ctrl_d     = bus.byteen[0] ? bus.wdata[TC_CTRL_W-1:0] : ctrl_q;
      count_d    = count_q;
      state_d    = TC_IDLE;
      irq_flag_d = 1'b0;
    end

    // Registered copy of flag & mask, identical to the AND of the flops
    irq_d = irq_flag_d & ctrl_d[TC_CTRL_IM_BIT];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      state_q    <= TC_IDLE;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      state_q    <= state_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_d;
    end
  end

  // Zero-latency read path, independent of sel
  always_comb begin
    case (bus.addr)
      TC_ADDR_CTRL:   bus.rdata = {{(32-TC_CTRL_W){1'b0}}, ctrl_q};
      TC_ADDR_PRESET: bus.rdata = preset_q;
      TC_ADDR_COUNT:  bus.rdata = count_q;
      default:        bus.rdata = 32'd0;
    endcase
  end

  assign bus.irq = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_tc_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tc_timer
// Description : Self-checking bench for tc_timer. A timeline-based reference
//               model computes the expected irq and read data each cycle and
//               pushes them to a scoreboard queue; a monitor on the falling
//               edge pops and compares against the DUT.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tc_timer;

  logic clk = 1'b0;
  logic reset;

  tc_timer_if bus ();

  tc_timer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        exp_irq;
    logic [31:0] exp_rdata;
    logic [1:0]  addr;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_no   = 0;

  // Reference model state: registers plus a start-edge timeline
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;
  bit          m_run;
  longint      m_s;
  longint      m_e;
  logic [31:0] m_nload;

  // Inputs currently applied (they take effect at the next edge)
  bit          s_sel;
  logic [1:0]  s_addr;
  logic [3:0]  s_be;
  logic [31:0] s_wd;
  bit          s_rst;

  function automatic logic [31:0] lane_merge(input logic [31:0] o,
                                             input logic [31:0] n,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_zero();
    m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0;
    m_run = 1'b0; m_s = 0; m_nload = 32'd0;
  endtask

  // One rising edge of the timeline. After a start at edge s:
  // s+1 load phase, s+2 COUNT=N, COUNT=N-(k-2) until 0 at s+N+2,
  // interrupt at s+N+3, then reload (restart with s'=s+N+3) or stop.
  task automatic model_edge();
    bit          wr;
    logic [31:0] next_preset;
    longint      k;
    longint      nl;
    m_e++;
    if (s_rst) return;
    wr = s_sel && (s_be != 4'd0);
    if (wr && s_addr == 2'd0) begin
      if (s_be[0]) m_ctrl = s_wd[3:0];
      m_flag = 1'b0;
      m_run  = m_ctrl[0];
      m_s    = m_e;
      return;
    end
    next_preset = (wr && s_addr == 2'd1) ? lane_merge(m_preset, s_wd, s_be) : m_preset;
    if (m_run) begin
      k  = m_e - m_s;
      nl = longint'(m_nload);
      if (k == 2) begin
        m_nload = m_preset;
        m_count = m_preset;
      end else if (k > 2 && k <= nl + 2) begin
        m_count = m_nload - 32'(k - 2);
      end else if (k == nl + 3) begin
        m_flag = 1'b1;
      end else if (k == nl + 4) begin
        if (m_ctrl[2:1] == 2'b01) begin
          m_flag = 1'b0;
          m_s    = m_e - 1;
        end else begin
          m_ctrl[0] = 1'b0;
          m_run     = 1'b0;
        end
      end
    end
    m_preset = next_preset;
  endtask

  // Advance one cycle: account for the edge, then apply new inputs and
  // push the response expected for the rest of this cycle.
  task automatic cyc(input bit sel, input logic [1:0] addr,
                     input logic [3:0] be, input logic [31:0] wd,
                     input bit rst = 1'b0);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    s_sel = sel; s_addr = addr; s_be = be; s_wd = wd; s_rst = rst;
    bus.sel = sel; bus.addr = addr; bus.byteen = be; bus.wdata = wd;
    reset = rst;
    if (rst) model_zero();
    cyc_no++;
    e.exp_irq   = m_flag & m_ctrl[3];
    e.exp_rdata = model_read(addr);
    e.addr      = addr;
    e.cyc       = cyc_no;
    sbq.push_back(e);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] wd,
                    input logic [3:0] be);
    cyc(1'b1, addr, be, wd);
  endtask

  task automatic idle(input int n, input logic [1:0] addr);
    for (int i = 0; i < n; i++) cyc(1'b0, addr, 4'd0, 32'd0);
  endtask

  // Monitor: compare DUT outputs away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_checks++;
        if (bus.irq !== e.exp_irq) begin
          n_fail++;
          $display("FAIL irq cyc %0d: got %0b expected %0b", e.cyc, bus.irq, e.exp_irq);
        end
        n_checks++;
        if (bus.rdata !== e.exp_rdata) begin
          n_fail++;
          $display("FAIL rdata[addr %0d] cyc %0d: got %08h expected %08h",
                   e.addr, e.cyc, bus.rdata, e.exp_rdata);
        end
      end
    end
  end

  initial begin
    int r;
    reset = 1'b1;
    bus.sel = 1'b0; bus.addr = 2'd0; bus.byteen = 4'd0; bus.wdata = 32'd0;
    s_sel = 1'b0; s_addr = 2'd0; s_be = 4'd0; s_wd = 32'd0; s_rst = 1'b1;
    m_e = 0;
    model_zero();

    // Reset state on every offset
    for (int a = 0; a < 4; a++) cyc(1'b0, 2'(a), 4'd0, 32'd0, 1'b1);
    idle(2, 2'd0);

    // One-shot
    wr(2'd1, 32'd3, 4'hF);
    wr(2'd0, 32'h9, 4'h1);
    idle(8, 2'd2);
    idle(2, 2'd0);
    wr(2'd0, 32'h8, 4'h1);
    idle(3, 2'd0);

    // Auto-reload
    wr(2'd0, 32'h0, 4'h1);
    wr(2'd1, 32'd2, 4'hF);
    wr(2'd0, 32'hB, 4'h1);
    idle(17, 2'd2);

    // Reset mid-count
    wr(2'd0, 32'h0, 4'h1);
    wr(2'd1, 32'd8, 4'hF);
    wr(2'd0, 32'h9, 4'h1);
    idle(5, 2'd2);
    for (int a = 0; a < 4; a++) cyc(1'b0, 2'(a), 4'd0, 32'd0, 1'b1);
    idle(2, 2'd2);

    // Masked interrupt with PRESET = 0
    wr(2'd1, 32'd0, 4'hF);
    wr(2'd0, 32'h1, 4'h1);
    idle(6, 2'd0);
    wr(2'd0, 32'h8, 4'h1);
    idle(3, 2'd0);

    // Byte lanes, COUNT write ignored, deselected write ignored
    wr(2'd0, 32'h0, 4'h1);
    wr(2'd1, 32'h11223344, 4'hF);
    wr(2'd1, 32'hAABBCCDD, 4'b0101);
    idle(1, 2'd1);
    wr(2'd2, 32'hFFFFFFFF, 4'hF);
    idle(1, 2'd2);
    cyc(1'b0, 2'd1, 4'hF, 32'h0);
    idle(1, 2'd1);
    wr(2'd3, 32'h12345678, 4'hF);
    idle(1, 2'd3);

    // CTRL write landing on the one-shot INT edge
    wr(2'd1, 32'd2, 4'hF);
    wr(2'd0, 32'h9, 4'h1);
    idle(5, 2'd0);
    wr(2'd0, 32'h9, 4'h1);
    idle(4, 2'd0);
    idle(4, 2'd2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 199));
      if (r < 8)
        wr(2'd0, {28'd0, 1'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0)}, 4'h1);
      else if (r < 16)
        wr(2'd1, 32'($urandom_range(0, 5)), 4'hF);
      else if (r < 18)
        wr(2'd1, $urandom, 4'($urandom));
      else if (r < 20)
        wr(2'd2, $urandom, 4'($urandom_range(1, 15)));
      else if (r < 22)
        wr(2'd3, $urandom, 4'($urandom_range(1, 15)));
      else if (r < 26)
        cyc(1'b0, 2'($urandom), 4'($urandom_range(1, 15)), $urandom);
      else if (r < 27)
        cyc(1'b0, 2'($urandom), 4'd0, 32'd0, 1'b1);
      else
        idle(1, 2'($urandom));
    end
    idle(2, 2'd0);

    @(negedge clk);
    #1;
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d entries left expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
